// File: rtl/ebus_pkg.sv
`default_nettype none
// ============================================================================
// ebus_pkg -- shared EBUS arbiter types and constants.       Rev 1.0
// ============================================================================
package ebus_pkg;

    localparam int EBUS_WIDTH = 36;

    typedef logic [0:EBUS_WIDTH-1] ebus_data_t;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_DRIVE   = 2'd1,
        ARB_DEMAND  = 2'd2,
        ARB_RELEASE = 2'd3
    } ebus_arb_state_t;

endpackage : ebus_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick -- combinational round-robin picker, first set req from ptr upward.
// Rev 1.0
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] j;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        sum    = '0;
        j      = '0;
        for (int k = 0; k < N; k++) begin
            // Wrap ptr+k back into 0..N-1 without a modulo operator
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            j = sum[IW-1:0];
            if (!valid && req[j]) begin
                onehot[j] = 1'b1;
                idx       = j;
                valid     = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/ebus_arbiter.sv
`default_nettype none
// ============================================================================
// ebus_arbiter -- round-robin EBUS arbiter with settle, DEMAND/ACK, timeout.
// Rev 1.0
// ============================================================================
module ebus_arbiter
    import ebus_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 63
) (
    input  logic                       clk,
    input  logic                       RESET,
    input  logic [NREQ-1:0]            req,
    input  ebus_data_t [NREQ-1:0]      reqData,
    output logic [NREQ-1:0]            grant,
    output ebus_data_t                 ebusData,
    output logic                       ebusDriving,
    output logic                       demand,
    input  logic                       ack,
    output logic                       busy,
    output logic                       timeoutErr,
    output logic [$clog2(NREQ)-1:0]    lastGrant
);

    localparam int IDXW = $clog2(NREQ);
    localparam int SCW  = $clog2(SETTLE + 1);
    localparam int TCW  = $clog2(TIMEOUT + 1);

    ebus_arb_state_t state;
    logic [IDXW-1:0] rr_ptr;
    logic [SCW-1:0]  settle_cnt;
    logic [TCW-1:0]  tmo_cnt;

    logic [NREQ-1:0] pick_onehot;
    logic [IDXW-1:0] pick_idx;
    logic            pick_valid;
    logic            req_held;

    rr_pick #(
        .N  (NREQ),
        .IW (IDXW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign req_held = |(req & grant);
    assign busy     = (state != ARB_IDLE);

    // AND-OR mux off the registered grant, so the bus reads zero when idle
    always_comb begin
        ebusData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                ebusData = ebusData | reqData[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state       <= ARB_IDLE;
            grant       <= '0;
            ebusDriving <= 1'b0;
            demand      <= 1'b0;
            timeoutErr  <= 1'b0;
            rr_ptr      <= '0;
            lastGrant   <= '0;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
        end else begin
            timeoutErr <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant       <= pick_onehot;
                        lastGrant   <= pick_idx;
                        ebusDriving <= 1'b1;
                        settle_cnt  <= SCW'(SETTLE - 1);
                        state       <= ARB_DRIVE;
                    end
                end
                ARB_DRIVE: begin
                    if (!req_held) begin
                        grant       <= '0;
                        ebusDriving <= 1'b0;
                        demand      <= 1'b0;
                        state       <= ARB_RELEASE;
                    end else if (settle_cnt == '0) begin
                        demand  <= 1'b1;
                        tmo_cnt <= TCW'(TIMEOUT);
                        state   <= ARB_DEMAND;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ARB_DEMAND: begin
                    // Abort and ack both beat an expiring timeout: neither flags an error
                    if (!req_held || ack || tmo_cnt == '0) begin
                        grant       <= '0;
                        ebusDriving <= 1'b0;
                        demand      <= 1'b0;
                        timeoutErr  <= req_held && !ack;
                        state       <= ARB_RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                ARB_RELEASE: begin
                    rr_ptr <= (lastGrant == IDXW'(NREQ - 1)) ? '0 : lastGrant + IDXW'(1);
                    state  <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule : ebus_arbiter
`default_nettype wire

// File: tb/tb_ebus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ebus_arbiter -- directed plan scenarios plus random traffic vs a model.
// Rev 1.0
// ============================================================================
module tb_ebus_arbiter;
    import ebus_pkg::*;

    localparam int NREQ    = 4;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 63;

    logic                  clk   = 1'b0;
    logic                  RESET = 1'b1;
    logic                  ack   = 1'b0;
    logic [NREQ-1:0]       req   = '0;
    ebus_data_t [NREQ-1:0] reqData = '0;
    logic [NREQ-1:0]       grant;
    ebus_data_t            ebusData;
    logic                  ebusDriving;
    logic                  demand;
    logic                  busy;
    logic                  timeoutErr;
    logic [1:0]            lastGrant;

    int n_checks = 0;
    int n_bad    = 0;

    // Transaction-level model: who owns the bus, and for how many cycles
    int m_owner = -1;
    int m_age   = 0;
    int m_ptr   = 0;
    int m_last  = 0;
    bit m_rel   = 1'b0;
    bit m_err   = 1'b0;

    ebus_arbiter #(
        .NREQ    (NREQ),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .RESET       (RESET),
        .req         (req),
        .reqData     (reqData),
        .grant       (grant),
        .ebusData    (ebusData),
        .ebusDriving (ebusDriving),
        .demand      (demand),
        .ack         (ack),
        .busy        (busy),
        .timeoutErr  (timeoutErr),
        .lastGrant   (lastGrant)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int i;
        if (RESET) begin
            m_owner = -1; m_age = 0; m_ptr = 0; m_last = 0; m_rel = 1'b0; m_err = 1'b0;
        end else if (m_rel) begin
            m_rel = 1'b0;
            m_err = 1'b0;
            m_ptr = (m_last + 1) % NREQ;
        end else if (m_owner >= 0) begin
            m_err = 1'b0;
            if (!req[2'(m_owner)]) begin
                m_owner = -1; m_rel = 1'b1;
            end else if (m_age >= SETTLE && ack) begin
                m_owner = -1; m_rel = 1'b1;
            end else if (m_age == SETTLE + TIMEOUT) begin
                m_owner = -1; m_rel = 1'b1; m_err = 1'b1;
            end else begin
                m_age++;
            end
        end else begin
            m_err = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (m_owner < 0 && req[2'(i)]) begin
                    m_owner = i; m_last = i; m_age = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [NREQ-1:0] eg;
        ebus_data_t      ed;
        eg = '0;
        ed = '0;
        if (m_owner >= 0) begin
            eg[2'(m_owner)] = 1'b1;
            ed = reqData[2'(m_owner)];
        end
        check_val("grant",      64'(grant),       64'(eg));
        check_val("driving",    64'(ebusDriving), 64'(m_owner >= 0));
        check_val("demand",     64'(demand),      64'(m_owner >= 0 && m_age >= SETTLE));
        check_val("busy",       64'(busy),        64'(m_owner >= 0 || m_rel));
        check_val("tmo_err",    64'(timeoutErr),  64'(m_err));
        check_val("last_grant", 64'(lastGrant),   64'(m_last));
        check_val("ebus_data",  64'(ebusData),    64'(ed));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        RESET = 1'b1; req = '0; ack = 1'b0;
        step(); step();
        RESET = 1'b0;
    endtask

    task automatic random_phase(input int cycles);
        logic [63:0] rnd;
        for (int c = 0; c < cycles; c++) begin
            RESET = ($urandom_range(0, 399) == 0);
            ack   = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NREQ; i++) begin
                rnd = {$urandom(), $urandom()};
                reqData[2'(i)] = rnd[35:0];
            end
            if (m_rel && $urandom_range(0, 3) != 0) req[2'(m_last)] = 1'b0;
            if (m_owner >= 0 && $urandom_range(0, 39) == 0) req[2'(m_owner)] = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req[2'(i)] && $urandom_range(0, 5) == 0) req[2'(i)] = 1'b1;
            end
            step();
        end
        RESET = 1'b0;
    endtask

    initial begin
        int order[$];
        int dcnt;
        int pulses;
        bit seen;
        bit prev;

        // Reset, then a single request with ack on the third DEMAND cycle
        do_reset();
        check_val("rst_grant", 64'(grant), 64'h0);
        reqData[0] = 36'o123456701234;
        req = 4'b0001;
        step();
        check_val("t1_grant_c1", 64'(grant), 64'h1);
        step(); step();
        check_val("t1_demand_c3", 64'(demand), 64'h1);
        check_val("t1_data_c3", 64'(ebusData), 64'(36'o123456701234));
        step(); step();
        ack = 1'b1;
        step();
        ack = 1'b0; req = '0;
        check_val("t1_release_c6", 64'({busy, ebusDriving, demand}), 64'(3'b100));
        req = 4'b0011;
        step(); step();
        check_val("t1_rrptr_next", 64'(grant), 64'(4'b0010));
        req = '0;
        step(); step(); step();

        // Round-robin fairness with all four requesting
        do_reset();
        req = 4'b1111; ack = 1'b1;
        prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (ebusDriving && !prev) order.push_back(int'(lastGrant));
            prev = ebusDriving;
        end
        for (int k = 0; k < 5; k++) begin
            check_val("rr_order", 64'(order.size() > k ? order[k] : -1), 64'(k % NREQ));
        end

        // Timeout on source 2
        do_reset();
        req = 4'b0100;
        dcnt = 0; pulses = 0; seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            step();
            if (demand) dcnt++;
            if (timeoutErr) begin
                seen = 1'b1;
                pulses++;
                check_val("tmo_grant_clear", 64'(grant), 64'h0);
                check_val("tmo_last_grant", 64'(lastGrant), 64'h2);
            end
        end
        check_val("tmo_seen", 64'(seen), 64'h1);
        check_val("tmo_demand_cycles", 64'(dcnt), 64'(TIMEOUT + 1));
        req = '0;
        step();
        check_val("tmo_single_pulse", 64'(timeoutErr), 64'h0);
        step();

        // Ack lands exactly as the timeout counter reaches zero
        do_reset();
        req = 4'b0001;
        dcnt = 0;
        for (int c = 0; c < 200 && dcnt < TIMEOUT + 1; c++) begin
            step();
            if (demand) dcnt++;
        end
        ack = 1'b1;
        step();
        ack = 1'b0; req = '0;
        check_val("coll_no_err", 64'(timeoutErr), 64'h0);
        check_val("coll_release", 64'({busy, ebusDriving}), 64'(2'b10));
        step();
        check_val("coll_no_err_late", 64'(timeoutErr), 64'h0);

        // Requester abort during DRIVE
        do_reset();
        req = 4'b0010;
        step();
        req = '0;
        step();
        check_val("abort_release", 64'({busy, ebusDriving, timeoutErr}), 64'(3'b100));
        step(); step();

        // Reset during DEMAND
        do_reset();
        req = 4'b0100;
        step(); step(); step();
        check_val("rstmid_in_demand", 64'(demand), 64'h1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check_val("rstmid_outputs", 64'({grant, busy, ebusDriving, demand, timeoutErr, lastGrant}), 64'h0);
        req = 4'b1111;
        step();
        check_val("rstmid_ptr_zero", 64'(grant), 64'(4'b0001));
        req = '0;
        step(); step(); step();

        // Source 3 arrives while source 0 is in DEMAND
        do_reset();
        req = 4'b0001;
        step(); step(); step();
        req = 4'b1001;
        step(); step();
        check_val("cont_wait", 64'(grant), 64'(4'b0001));
        ack = 1'b1;
        step();
        ack = 1'b0; req = 4'b1000;
        step();
        check_val("cont_dead_cycle", 64'(grant), 64'h0);
        step();
        check_val("cont_grant3", 64'(grant), 64'(4'b1000));
        req = '0;
        step(); step(); step();

        // Random traffic against the model
        do_reset();
        random_phase(2500);
        req = '0;
        step(); step(); step();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule : tb_ebus_arbiter
`default_nettype wire
